// File: rtl/stopwatch_control.sv
// Pushbutton front end for the stopwatch timer: synchronizes, debounces and decodes the
// KEY presses into run enable, clear pulse and, when STOPWATCH_LAP_EN is defined, a lap freeze.

module stopwatch_button #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_level;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync_meta  <= 1'b1;
            sync_level <= 1'b1;
        end else begin
            sync_meta  <= key_n;
            sync_level <= sync_meta;
        end
    end

    // Any single cycle where the synchronized level agrees with the accepted one restarts the count.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync_level == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign press = level && !sync_level && (cnt == CNT_LAST);

endmodule

module stopwatch_control #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_startstop_n,
    input  logic       key_clear_n,
    input  logic       key_lap_n,
    output logic       enable,
    output logic       clear_pulse,
    output logic       lap_freeze,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } run_state_t;

    logic       startstop_press;
    logic       clear_press;
    logic       lap_press;
    run_state_t state_q;
    run_state_t state_d;
    logic       enable_d;
    logic       clear_d;
    logic       freeze_q;
    logic       freeze_d;

    stopwatch_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_startstop (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .key_n   (key_startstop_n),
        .press   (startstop_press)
    );

    stopwatch_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .key_n   (key_clear_n),
        .press   (clear_press)
    );

`ifdef STOPWATCH_LAP_EN
    localparam logic LAP_BUILT = 1'b1;

    stopwatch_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_lap (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .key_n   (key_lap_n),
        .press   (lap_press)
    );
`else
    localparam logic LAP_BUILT = 1'b0;

    logic unused_lap_key;

    assign unused_lap_key = key_lap_n;
    assign lap_press      = 1'b0;
`endif

    // Outputs are registered alongside the state so the timer sees clean levels.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            enable      <= 1'b0;
            clear_pulse <= 1'b0;
            freeze_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable      <= enable_d;
            clear_pulse <= clear_d;
            freeze_q    <= freeze_d & LAP_BUILT;
        end
    end

    // Clear overrides every other press arriving on the same cycle.
    always_comb begin
        state_d  = state_q;
        enable_d = enable;
        clear_d  = 1'b0;
        freeze_d = freeze_q;
        if (clear_press) begin
            state_d  = ST_IDLE;
            enable_d = 1'b0;
            clear_d  = 1'b1;
            freeze_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    freeze_d = 1'b0;
                    if (startstop_press) begin
                        state_d  = ST_RUN;
                        enable_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (lap_press) begin
                        freeze_d = !freeze_q;
                    end
                    if (startstop_press) begin
                        state_d  = ST_PAUSE;
                        enable_d = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (lap_press) begin
                        freeze_d = 1'b0;
                    end
                    if (startstop_press) begin
                        state_d  = ST_RUN;
                        enable_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                    freeze_d = 1'b0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign lap_freeze = freeze_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control with DEBOUNCE_CYCLES=4: vector table, hand-written press
// sequences and randomized buttons against a window-based reference model.

module tb_stopwatch_control;

    localparam int DC = 4;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       key_startstop_n;
    logic       key_clear_n;
    logic       key_lap_n;
    logic       enable;
    logic       clear_pulse;
    logic       lap_freeze;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_control #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3)
    ) dut (
        .CLOCK_50       (clk),
        .resetn         (resetn),
        .key_startstop_n(key_startstop_n),
        .key_clear_n    (key_clear_n),
        .key_lap_n      (key_lap_n),
        .enable         (enable),
        .clear_pulse    (clear_pulse),
        .lap_freeze     (lap_freeze),
        .state          (state)
    );

    // Reference model: a button level is accepted once the last DC synchronized samples all disagree with it.
    bit       m_pipe [3][2];
    bit       m_win  [3][DC];
    int       m_fill [3];
    bit       m_level[3];
    bit [1:0] m_state;
    bit       m_cp;
    bit       m_lf;

    task automatic model_edge(input bit rstn, input bit [2:0] raw);
        bit [2:0] ev;
        bit       s;
        bit       all_diff;
        if (!rstn) begin
            for (int b = 0; b < 3; b++) begin
                m_pipe[b][0] = 1'b1;
                m_pipe[b][1] = 1'b1;
                m_fill[b]    = 0;
                m_level[b]   = 1'b1;
            end
            m_state = 2'd0;
            m_cp    = 1'b0;
            m_lf    = 1'b0;
            return;
        end
        ev = '0;
        for (int b = 0; b < 3; b++) begin
            s            = m_pipe[b][1];
            m_pipe[b][1] = m_pipe[b][0];
            m_pipe[b][0] = raw[b];
            for (int i = DC - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
            m_win[b][0] = s;
            if (m_fill[b] < DC) m_fill[b]++;
            all_diff = (m_fill[b] == DC);
            for (int i = 0; i < DC; i++) if (m_win[b][i] == m_level[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[b] = s;
                ev[b]      = !s;
            end
        end
        if (!LAP_EN) ev[2] = 1'b0;
        m_cp = 1'b0;
        if (ev[1]) begin
            m_state = 2'd0;
            m_cp    = 1'b1;
            m_lf    = 1'b0;
        end else if (m_state == 2'd1) begin
            if (ev[2]) m_lf = !m_lf;
            if (ev[0]) m_state = 2'd2;
        end else if (m_state == 2'd2) begin
            if (ev[2]) m_lf = 1'b0;
            if (ev[0]) m_state = 2'd1;
        end else if (ev[0]) begin
            m_state = 2'd1;
        end
    endtask

    task automatic applyStimulus(input bit rstn, input bit ss, input bit cl, input bit lp);
        resetn          = rstn;
        key_startstop_n = ss;
        key_clear_n     = cl;
        key_lap_n       = lp;
        @(posedge clk);
        model_edge(rstn, {lp, cl, ss});
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input bit [1:0] st, input bit en,
                               input bit cp, input bit lf);
        checks++;
        if ({state, enable, clear_pulse, lap_freeze} !== {st, en, cp, lf}) begin
            errors++;
            $display("[TB] FAIL %s: got state=%b en=%b clr=%b lap=%b, want state=%b en=%b clr=%b lap=%b",
                     name, state, enable, clear_pulse, lap_freeze, st, en, cp, lf);
        end
    endtask

    // Holds the given keys low for 7 edges; the change must land exactly on edge 6.
    task automatic pressAndCheck(input string name, input bit ss, input bit cl, input bit lp,
                                 input bit [1:0] pre_st, input bit pre_en, input bit pre_lf,
                                 input bit [1:0] st, input bit en, input bit cp, input bit lf);
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1'b1, ss, cl, lp);
            if (e == 5) checkOutput({name, "_before"}, pre_st, pre_en, 1'b0, pre_lf);
            if (e == 6) checkOutput(name, st, en, cp, lf);
            if (e == 7) checkOutput({name, "_after"}, st, en, 1'b0, lf);
        end
        for (int e = 0; e < 7; e++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    typedef struct {
        bit       rstn;
        bit       ss;
        bit       cl;
        bit       lp;
        bit [1:0] st;
        bit       en;
        bit       cp;
        bit       lf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_rows(input int n, input bit rstn, input bit ss,
                                     input bit [1:0] st, input bit en);
        vec_t v;
        v.rstn = rstn;
        v.ss   = ss;
        v.cl   = 1'b1;
        v.lp   = 1'b1;
        v.st   = st;
        v.en   = en;
        v.cp   = 1'b0;
        v.lf   = 1'b0;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        bit [2:0] lvl_r;
        int       hold_r[3];
        bit       bounce[10];

        resetn          = 1'b0;
        key_startstop_n = 1'b1;
        key_clear_n     = 1'b1;
        key_lap_n       = 1'b1;

        add_rows(1, 1'b0, 1'b1, 2'b00, 1'b0);
        add_rows(3, 1'b0, 1'b0, 2'b00, 1'b0);
        add_rows(5, 1'b1, 1'b0, 2'b00, 1'b0);
        add_rows(5, 1'b1, 1'b0, 2'b01, 1'b1);
        add_rows(7, 1'b1, 1'b1, 2'b01, 1'b1);
        add_rows(5, 1'b1, 1'b0, 2'b01, 1'b1);
        add_rows(1, 1'b1, 1'b0, 2'b10, 1'b0);
        add_rows(7, 1'b1, 1'b1, 2'b10, 1'b0);
        add_rows(5, 1'b1, 1'b0, 2'b10, 1'b0);
        add_rows(1, 1'b1, 1'b0, 2'b01, 1'b1);

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstn, vecs[i].ss, vecs[i].cl, vecs[i].lp);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].cp, vecs[i].lf);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("reset_from_run", 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

        bounce = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
        foreach (bounce[i]) begin
            applyStimulus(1'b1, bounce[i], 1'b1, 1'b1);
            checkOutput("bounce", 2'b00, 1'b0, 1'b0, 1'b0);
        end
        for (int e = 1; e <= 6; e++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
            if (e < 6) checkOutput("bounce_settle", 2'b00, 1'b0, 1'b0, 1'b0);
            else       checkOutput("bounce_run", 2'b01, 1'b1, 1'b0, 1'b0);
        end
        for (int e = 0; e < 7; e++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

        pressAndCheck("clear_beats_ss", 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        pressAndCheck("clear_idle",     1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);

        pressAndCheck("run",        1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0,   2'b01, 1'b1, 1'b0, 1'b0);
        pressAndCheck("lap_run",    1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0,   2'b01, 1'b1, 1'b0, LAP_EN);
        pressAndCheck("pause",      1'b0, 1'b1, 1'b1, 2'b01, 1'b1, LAP_EN, 2'b10, 1'b0, 1'b0, LAP_EN);
        pressAndCheck("lap_pause",  1'b1, 1'b1, 1'b0, 2'b10, 1'b0, LAP_EN, 2'b10, 1'b0, 1'b0, 1'b0);
        pressAndCheck("resume",     1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0,   2'b01, 1'b1, 1'b0, 1'b0);
        pressAndCheck("lap_run2",   1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0,   2'b01, 1'b1, 1'b0, LAP_EN);
        pressAndCheck("ss_lap_run", 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, LAP_EN, 2'b10, 1'b0, 1'b0, 1'b0);
        pressAndCheck("resume2",    1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0,   2'b01, 1'b1, 1'b0, 1'b0);
        pressAndCheck("lap_run3",   1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0,   2'b01, 1'b1, 1'b0, LAP_EN);
        pressAndCheck("clear_lap",  1'b1, 1'b0, 1'b1, 2'b01, 1'b1, LAP_EN, 2'b00, 1'b0, 1'b1, 1'b0);
        pressAndCheck("lap_idle",   1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0,   2'b00, 1'b0, 1'b0, 1'b0);

        pressAndCheck("run_again",  1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0,   2'b01, 1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("mid_clear_debounce", 2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_mid_debounce", 2'b00, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 8; e++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
            checkOutput("no_pulse_after_reset", 2'b00, 1'b0, 1'b0, 1'b0);
        end
        pressAndCheck("clear_after_reset", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        pressAndCheck("run_after_reset",   1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        lvl_r = 3'b111;
        for (int b = 0; b < 3; b++) hold_r[b] = 1;
        for (int c = 0; c < 3000; c++) begin
            bit rst_b;
            for (int b = 0; b < 3; b++) begin
                if (hold_r[b] == 0) begin
                    lvl_r[b]  = ~lvl_r[b];
                    hold_r[b] = (b == 1 && lvl_r[b]) ? int'($urandom_range(10, 60))
                                                     : int'($urandom_range(1, 10));
                end
                hold_r[b]--;
            end
            rst_b = ($urandom_range(0, 399) != 0);
            applyStimulus(rst_b, lvl_r[0], lvl_r[1], lvl_r[2]);
            checkOutput("random", m_state, m_state == 2'd1, m_cp, m_lf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
